// File: rtl/rtc_bcd_ctrl_pkg.sv
// Shared types and BCD helpers for the real-time-clock core.
// Holds the time-field limits and the 12 h display conversion.
package rtc_pkg;

   typedef logic [7:0] bcd8_t;

   localparam bcd8_t SEC_MAX  = 8'h59;
   localparam bcd8_t MIN_MAX  = 8'h59;
   localparam bcd8_t HOUR_MAX = 8'h23;

   function automatic logic bcd_valid(input bcd8_t value, input bcd8_t max);
      return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= max);
   endfunction

   function automatic bcd8_t bcd_inc(input bcd8_t value, input bcd8_t max);
      bcd8_t r;
      if (value == max)
         r = '0;
      else if (value[3:0] == 4'd9)
         r = {value[7:4] + 4'd1, 4'd0};
      else
         r = {value[7:4], value[3:0] + 4'd1};
      return r;
   endfunction

   // Returns {pm, bcd_hour}; subtracting 12 is done per tens digit.
   function automatic logic [8:0] to_12h(input bcd8_t hour);
      logic [8:0] r;
      r = {1'b0, hour};
      if (hour == 8'h00)
         r = {1'b0, 8'h12};
      else if (hour == 8'h12)
         r = {1'b1, 8'h12};
      else if (hour > 8'h12) begin
         if (hour[7:4] == 4'd1)
            r = {1'b1, 4'h0, hour[3:0] - 4'd2};
         else if (hour[3:0] < 4'd2)
            r = {1'b1, 4'h0, hour[3:0] + 4'd8};
         else
            r = {1'b1, 4'h1, hour[3:0] - 4'd2};
      end
      return r;
   endfunction

endpackage

// File: rtl/rtc_bcd_ctrl_if.sv
// Time-set handshake bundle between a host and the RTC core.
// The host drives request and BCD data; the core answers ready/err.
interface rtc_bcd_ctrl_if;
   import rtc_pkg::*;

   logic  set_valid;
   logic  set_ready;
   logic  set_err;
   bcd8_t set_hour;
   bcd8_t set_min;
   bcd8_t set_sec;

   modport master (
      output set_valid, set_hour, set_min, set_sec,
      input  set_ready, set_err
   );

   modport slave (
      input  set_valid, set_hour, set_min, set_sec,
      output set_ready, set_err
   );

endinterface

// File: rtl/rtc_bcd_ctrl_bcd_mod_counter.sv
// Two-digit BCD modulo counter with parallel load.
// carry flags the increment that wraps MAX_BCD back to 00.
module bcd_mod_counter
   import rtc_pkg::*;
#(
   parameter bcd8_t MAX_BCD = 8'h59
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  inc,
   input  logic  load,
   input  bcd8_t load_val,
   output bcd8_t value,
   output logic  carry
);

   assign carry = inc && (value == MAX_BCD);

   // Load has priority over increment.
   always_ff @(posedge clk) begin
      if (rst)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (inc)
         value <= bcd_inc(value, MAX_BCD);
   end

endmodule

// File: rtl/rtc_bcd_ctrl.sv
// BCD real-time clock: 1 Hz prescaler, hh:mm:ss chain, time set,
// 12/24 h registered display, separator blink and sticky alarm.
module rtc_bcd_ctrl
   import rtc_pkg::*;
#(
   parameter int CLK_FREQ_HZ       = 50_000_000,
   parameter int TICK_DIV_OVERRIDE = 0,
   parameter int BLINK_DIV         = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           run,
   input  logic           mode_12h,
   rtc_bcd_ctrl_if.slave  set_bus,
   input  logic           alm_en,
   input  bcd8_t          alm_hour,
   input  bcd8_t          alm_min,
   input  logic           alm_ack,
   output bcd8_t          hour,
   output bcd8_t          min,
   output bcd8_t          sec,
   output logic           pm,
   output logic           tick_1hz,
   output logic           blink,
   output logic           alarm
);

   localparam int DIV  = (TICK_DIV_OVERRIDE != 0) ? TICK_DIV_OVERRIDE
                                                  : CLK_FREQ_HZ;
   localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int HRAW = DIV / BLINK_DIV;
   localparam int HALF = (HRAW > 0) ? HRAW : 1;
   localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);
   localparam logic [BW-1:0] BL_LAST = BW'(HALF - 1);

   logic [PW-1:0] ps_cnt;
   logic [BW-1:0] bl_cnt;
   bcd8_t         sec_q, min_q, hour_q;
   bcd8_t         min_nx, hour_nx;
   logic          sec_carry, min_carry, hour_carry;
   logic          xfer, ok, load, bad, wrap, tick;
   logic          tick_match, set_match;

   assign set_bus.set_ready = !rst;

   assign xfer = set_bus.set_valid && set_bus.set_ready;
   assign ok   = bcd_valid(set_bus.set_hour, HOUR_MAX) &&
                 bcd_valid(set_bus.set_min, MIN_MAX) &&
                 bcd_valid(set_bus.set_sec, SEC_MAX);
   assign load = xfer && ok;
   assign bad  = xfer && !ok;

   // A valid set in the wrap cycle swallows that tick.
   assign wrap = run && (ps_cnt == PS_LAST);
   assign tick = wrap && !load;

   // Prescaler; a load restarts a full second.
   always_ff @(posedge clk) begin
      if (rst)
         ps_cnt <= '0;
      else if (load || wrap)
         ps_cnt <= '0;
      else if (run)
         ps_cnt <= ps_cnt + 1'b1;
   end

   // Separator blink, re-aligned to the second boundary on each wrap.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         bl_cnt <= '0;
         blink  <= 1'b1;
      end else if (run) begin
         if (wrap || bl_cnt == BL_LAST) begin
            bl_cnt <= '0;
            blink  <= ~blink;
         end else begin
            bl_cnt <= bl_cnt + 1'b1;
         end
      end
   end

   bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_sec (
      .clk      (clk),
      .rst      (rst),
      .inc      (tick),
      .load     (load),
      .load_val (set_bus.set_sec),
      .value    (sec_q),
      .carry    (sec_carry)
   );

   bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_min (
      .clk      (clk),
      .rst      (rst),
      .inc      (sec_carry),
      .load     (load),
      .load_val (set_bus.set_min),
      .value    (min_q),
      .carry    (min_carry)
   );

   bcd_mod_counter #(.MAX_BCD(HOUR_MAX)) u_hour (
      .clk      (clk),
      .rst      (rst),
      .inc      (min_carry),
      .load     (load),
      .load_val (set_bus.set_hour),
      .value    (hour_q),
      .carry    (hour_carry)
   );

   // Alarm compares against the time the counters are about to hold.
   assign min_nx     = sec_carry ? bcd_inc(min_q, MIN_MAX) : min_q;
   assign hour_nx    = min_carry ? bcd_inc(hour_q, HOUR_MAX) : hour_q;
   assign tick_match = sec_carry && (min_nx == alm_min) &&
                       (hour_nx == alm_hour);
   assign set_match  = load && (set_bus.set_sec == 8'h00) &&
                       (set_bus.set_min == alm_min) &&
                       (set_bus.set_hour == alm_hour);

   // Registered display and status pulses, one cycle behind the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         hour            <= '0;
         min             <= '0;
         sec             <= '0;
         pm              <= 1'b0;
         tick_1hz        <= 1'b0;
         set_bus.set_err <= 1'b0;
      end else begin
         sec             <= sec_q;
         min             <= min_q;
         {pm, hour}      <= mode_12h ? to_12h(hour_q) : {1'b0, hour_q};
         tick_1hz        <= tick;
         set_bus.set_err <= bad;
      end
   end

   // Sticky alarm; a new match beats a simultaneous acknowledge.
   always_ff @(posedge clk) begin
      if (rst)
         alarm <= 1'b0;
      else if (alm_en && (tick_match || set_match))
         alarm <= 1'b1;
      else if (alm_ack)
         alarm <= 1'b0;
   end

endmodule

// File: tb/tb_rtc_bcd_ctrl.sv
// Randomised bench for rtc_bcd_ctrl: a seconds-of-day reference model
// queues expected outputs each edge; a monitor checks on the falling edge.
module tb_rtc_bcd_ctrl;
   import rtc_pkg::*;

   localparam int DIV  = 4;
   localparam int HALF = DIV / 2;

   typedef struct packed {
      logic [7:0] hour;
      logic [7:0] min;
      logic [7:0] sec;
      logic       pm;
      logic       tick;
      logic       blink;
      logic       alarm;
      logic       err;
   } obs_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  run = 1'b0;
   logic  mode_12h = 1'b0;
   logic  alm_en = 1'b0;
   logic  alm_ack = 1'b0;
   bcd8_t alm_hour = 8'h00;
   bcd8_t alm_min = 8'h00;
   bcd8_t hour, min, sec;
   logic  pm, tick_1hz, blink, alarm;

   int checks = 0;
   int errors = 0;
   obs_t exp_q[$];

   int m_t = 0;
   int m_cnt = 0;
   logic m_alarm = 1'b0;

   rtc_bcd_ctrl_if sif();

   rtc_bcd_ctrl #(
      .CLK_FREQ_HZ       (50_000_000),
      .TICK_DIV_OVERRIDE (DIV),
      .BLINK_DIV         (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .mode_12h (mode_12h),
      .set_bus  (sif),
      .alm_en   (alm_en),
      .alm_hour (alm_hour),
      .alm_min  (alm_min),
      .alm_ack  (alm_ack),
      .hour     (hour),
      .min      (min),
      .sec      (sec),
      .pm       (pm),
      .tick_1hz (tick_1hz),
      .blink    (blink),
      .alarm    (alarm)
   );

   always #5 clk = ~clk;

   function automatic bcd8_t to_bcd(input int v);
      return bcd8_t'(((v / 10) * 16) + (v % 10));
   endfunction

   function automatic int bcd2int(input bcd8_t v);
      if (v[7:4] > 4'd9 || v[3:0] > 4'd9)
         return -1;
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   // Reference model: time as seconds of day, prescaler as plain count.
   initial begin
      obs_t e;
      int   sh, sm, ss, hh, dh;
      logic ok, ld, wr, chg;
      forever begin
         @(posedge clk);
         e = '0;
         if (rst) begin
            m_t = 0;
            m_cnt = 0;
            m_alarm = 1'b0;
            e.blink = 1'b1;
         end else begin
            hh = m_t / 3600;
            if (mode_12h) begin
               dh = hh % 12;
               if (dh == 0) dh = 12;
               e.pm = (hh >= 12);
            end else begin
               dh = hh;
            end
            e.hour = to_bcd(dh);
            e.min  = to_bcd((m_t / 60) % 60);
            e.sec  = to_bcd(m_t % 60);
            sh = bcd2int(sif.set_hour);
            sm = bcd2int(sif.set_min);
            ss = bcd2int(sif.set_sec);
            ok = sh >= 0 && sh <= 23 && sm >= 0 && sm <= 59 &&
                 ss >= 0 && ss <= 59;
            ld = sif.set_valid && ok;
            wr = run && (m_cnt == DIV - 1);
            e.tick = wr && !ld;
            e.err  = sif.set_valid && !ok;
            chg = 1'b0;
            if (ld) begin
               m_t = sh * 3600 + sm * 60 + ss;
               m_cnt = 0;
               chg = 1'b1;
            end else if (run) begin
               m_cnt = (m_cnt + 1) % DIV;
               if (wr) begin
                  m_t = (m_t + 1) % 86400;
                  chg = 1'b1;
               end
            end
            if (chg && alm_en &&
                m_t == bcd2int(alm_hour) * 3600 + bcd2int(alm_min) * 60)
               m_alarm = 1'b1;
            else if (alm_ack)
               m_alarm = 1'b0;
            e.alarm = m_alarm;
            e.blink = ((m_cnt / HALF) % 2) == 0;
         end
         exp_q.push_back(e);
      end
   end

   // Monitor: compare DUT outputs against the queued expectation.
   initial begin
      obs_t e, a;
      forever begin
         @(negedge clk);
         checks++;
         if (sif.set_ready !== !rst) begin
            errors++;
            $display("FAIL set_ready @%0t: got %b expected %b",
                     $time, sif.set_ready, !rst);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.hour  = hour;
            a.min   = min;
            a.sec   = sec;
            a.pm    = pm;
            a.tick  = tick_1hz;
            a.blink = blink;
            a.alarm = alarm;
            a.err   = sif.set_err;
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs @%0t: got %h:%h:%h pm=%b tick=%b blink=%b alarm=%b err=%b expected %h:%h:%h pm=%b tick=%b blink=%b alarm=%b err=%b",
                        $time, a.hour, a.min, a.sec, a.pm, a.tick, a.blink,
                        a.alarm, a.err, e.hour, e.min, e.sec, e.pm, e.tick,
                        e.blink, e.alarm, e.err);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_set(input bcd8_t h, input bcd8_t m, input bcd8_t s);
      sif.set_hour  = h;
      sif.set_min   = m;
      sif.set_sec   = s;
      sif.set_valid = 1'b1;
      step();
      sif.set_valid = 1'b0;
   endtask

   task automatic load_fields(input int t);
      sif.set_hour = to_bcd(t / 3600);
      sif.set_min  = to_bcd((t / 60) % 60);
      sif.set_sec  = to_bcd(t % 60);
   endtask

   initial begin
      int r, t;
      sif.set_valid = 1'b1;
      sif.set_hour  = 8'h05;
      sif.set_min   = 8'h06;
      sif.set_sec   = 8'h07;

      // Reset with a pending request, then release in 12 h mode.
      step(3);
      rst = 1'b0;
      sif.set_valid = 1'b0;
      mode_12h = 1'b1;
      step(2);
      mode_12h = 1'b0;

      // Rollover through midnight.
      run = 1'b1;
      do_set(8'h23, 8'h59, 8'h58);
      step(8);

      // Rejected requests.
      do_set(8'h24, 8'h00, 8'h00);
      do_set(8'h12, 8'h5A, 8'h00);
      step(2);

      // 12 h conversion corners.
      mode_12h = 1'b1;
      do_set(8'h00, 8'h10, 8'h00);
      step();
      do_set(8'h12, 8'h10, 8'h00);
      step();
      do_set(8'h13, 8'h10, 8'h00);
      step();
      do_set(8'h23, 8'h10, 8'h00);
      step();
      mode_12h = 1'b0;

      // Alarm set by a tick, then acknowledged.
      alm_hour = 8'h07;
      alm_min  = 8'h30;
      alm_en   = 1'b1;
      do_set(8'h07, 8'h29, 8'h59);
      step(DIV + 1);
      alm_ack = 1'b1;
      step(2 * DIV + 2);
      alm_ack = 1'b0;

      // Set colliding with a tick.
      do_set(8'h10, 8'h00, 8'h00);
      step(DIV - 1);
      do_set(8'h11, 8'h11, 8'h11);
      step(DIV + 1);

      // Frozen time still accepts sets.
      run = 1'b0;
      step(5);
      do_set(8'h01, 8'h02, 8'h03);
      step(3);
      run = 1'b1;
      step(2);

      // Reset mid-count with a request pending.
      sif.set_hour  = 8'h08;
      sif.set_min   = 8'h08;
      sif.set_sec   = 8'h08;
      sif.set_valid = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      sif.set_valid = 1'b0;
      step(3);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         if (i % 400 == 0) begin
            alm_hour = to_bcd($urandom_range(0, 23));
            alm_min  = to_bcd($urandom_range(0, 59));
         end
         run = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 63) == 0) mode_12h = ~mode_12h;
         if ($urandom_range(0, 99) == 0) alm_en = ~alm_en;
         alm_ack = ($urandom_range(0, 31) == 0);
         sif.set_valid = ($urandom_range(0, 29) == 0);
         if (sif.set_valid) begin
            r = $urandom_range(0, 7);
            if (r == 0) begin
               sif.set_hour = 8'($urandom);
               sif.set_min  = 8'($urandom);
               sif.set_sec  = 8'($urandom);
            end else if (r <= 3) begin
               t = bcd2int(alm_hour) * 3600 + bcd2int(alm_min) * 60;
               load_fields((t + 86400 - r + 1) % 86400);
            end else begin
               load_fields(int'($urandom_range(0, 86399)));
            end
         end
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0;
      sif.set_valid = 1'b0;
      alm_ack = 1'b0;
      step(3);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending expected 0",
                  exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
